// File: rtl/alu_acc.sv
// -----------------------------------------------------------------------------
// alu_acc -- accumulator + ALU stage feeding the flags register.
//
// Holds the WIDTH-bit accumulator and executes one operation per accepted
// start. Most operations complete at the edge that samples start. MUL
// (shift-add) and DIV (restoring) iterate once per clock for WIDTH clocks.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset (also aborts MUL/DIV)
//   start   : execute op; sampled only while busy=0
//   op[3:0] : operation code, sampled with start
//   b       : second operand, sampled with start
//   cy      : current carry flag from the flags register (ADC/SBB)
//   acc     : accumulator register
//   hi      : high product (MUL) / remainder (DIV) register
//   cy_new  : registered carry result
//   ov_new  : registered overflow result
//   ce_cy   : one-cycle strobe telling the flags register to load cy/ov
//   busy    : MUL/DIV iteration in progress
//   done    : one-cycle pulse, result written at the preceding edge
// -----------------------------------------------------------------------------
module alu_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic             cy,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] hi,
  output logic             cy_new,
  output logic             ov_new,
  output logic             ce_cy,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cy_new_q, cy_new_d;
  logic             ov_new_q, ov_new_d;
  logic             ce_cy_q, ce_cy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Working registers for MUL/DIV so acc/hi stay stable until completion.
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  // ---------------------------------------------------------------------------
  // Single-cycle arithmetic (uses live b/cy inputs, only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic             carry_in;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic             add_ov;
  logic             sub_ov;

  assign carry_in = ((op == OP_ADC) || (op == OP_SBB)) ? cy : 1'b0;
  assign add_res  = {1'b0, acc_q} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  // Bit WIDTH of the extended difference is the unsigned borrow.
  assign sub_res  = {1'b0, acc_q} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
  assign add_ov   = (acc_q[WIDTH-1] == b[WIDTH-1]) &&
                    (add_res[WIDTH-1] != acc_q[WIDTH-1]);
  assign sub_ov   = (acc_q[WIDTH-1] != b[WIDTH-1]) &&
                    (sub_res[WIDTH-1] != acc_q[WIDTH-1]);

  // ---------------------------------------------------------------------------
  // MUL iteration: {work_hi, work_lo} holds {partial product, multiplier}.
  // Add the multiplicand when the multiplier LSB is set, then shift right.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  assign mul_sum   = {1'b0, work_hi_q} +
                     (work_lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // DIV iteration: {work_hi, work_lo} holds {remainder, dividend/quotient}.
  // Shift one dividend bit into the remainder and try subtracting the divisor;
  // the remainder stays < divisor, so WIDTH+1 bits are enough for the trial.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;
  logic [WIDTH-1:0] div_hi_nx;
  logic [WIDTH-1:0] div_lo_nx;

  assign div_sh    = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opb_q};
  assign div_fits  = ~div_trial[WIDTH];
  assign div_hi_nx = div_fits ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_nx = {work_lo_q[WIDTH-2:0], div_fits};

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    cy_new_d  = cy_new_q;
    ov_new_d  = ov_new_q;
    ce_cy_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opb_d     = opb_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          unique case (op)
            OP_LD: begin
              acc_d = b;
            end
            OP_ADD, OP_ADC: begin
              acc_d    = add_res[WIDTH-1:0];
              cy_new_d = add_res[WIDTH];
              ov_new_d = add_ov;
              ce_cy_d  = 1'b1;
            end
            OP_SUB, OP_SBB: begin
              acc_d    = sub_res[WIDTH-1:0];
              cy_new_d = sub_res[WIDTH];
              ov_new_d = sub_ov;
              ce_cy_d  = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              if (op == OP_AND)      acc_d = acc_q & b;
              else if (op == OP_OR)  acc_d = acc_q | b;
              else                   acc_d = acc_q ^ b;
              cy_new_d = 1'b0;
              ov_new_d = 1'b0;
              ce_cy_d  = 1'b1;
            end
            OP_SHL: begin
              acc_d    = {acc_q[WIDTH-2:0], 1'b0};
              cy_new_d = acc_q[WIDTH-1];
              ov_new_d = acc_q[WIDTH-1] ^ acc_q[WIDTH-2];
              ce_cy_d  = 1'b1;
            end
            OP_SHR: begin
              acc_d    = {1'b0, acc_q[WIDTH-1:1]};
              cy_new_d = acc_q[0];
              ov_new_d = 1'b0;
              ce_cy_d  = 1'b1;
            end
            OP_MUL: begin
              done_d    = 1'b0;
              busy_d    = 1'b1;
              cnt_d     = CNT_W'(WIDTH);
              work_hi_d = '0;
              work_lo_d = acc_q;
              opb_d     = b;
              state_d   = S_MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                // Divide by zero completes at once, leaving acc/hi intact.
                cy_new_d = 1'b1;
                ov_new_d = 1'b1;
                ce_cy_d  = 1'b1;
              end else begin
                done_d    = 1'b0;
                busy_d    = 1'b1;
                cnt_d     = CNT_W'(WIDTH);
                work_hi_d = '0;
                work_lo_d = acc_q;
                opb_d     = b;
                state_d   = S_DIV;
              end
            end
            default: begin
              // Reserved codes acknowledge with done but change nothing.
            end
          endcase
        end
      end

      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (state_q == S_MUL) begin
          work_hi_d = mul_hi_nx;
          work_lo_d = mul_lo_nx;
        end else begin
          work_hi_d = div_hi_nx;
          work_lo_d = div_lo_nx;
        end
        if (cnt_q == CNT_W'(1)) begin
          acc_d   = work_lo_d;
          hi_d    = work_hi_d;
          ce_cy_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (state_q == S_MUL) begin
            cy_new_d = (work_hi_d != '0);
            ov_new_d = (work_hi_d != '0);
          end else begin
            cy_new_d = 1'b0;
            ov_new_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      hi_q      <= '0;
      cy_new_q  <= 1'b0;
      ov_new_q  <= 1'b0;
      ce_cy_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opb_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      cy_new_q  <= cy_new_d;
      ov_new_q  <= ov_new_d;
      ce_cy_q   <= ce_cy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opb_q     <= opb_d;
    end
  end

  assign acc    = acc_q;
  assign hi     = hi_q;
  assign cy_new = cy_new_q;
  assign ov_new = ov_new_q;
  assign ce_cy  = ce_cy_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_acc.sv
// -----------------------------------------------------------------------------
// tb_alu_acc -- directed bench for alu_acc (WIDTH=8).
// Single-cycle ops come from a table of {op, b, cy, expected outputs};
// MUL/DIV, divide-by-zero, ignored start and mid-operation reset are
// hand-written sequences. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_alu_acc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op_in;
  logic [W-1:0] b_in;
  logic         cy_in;
  logic [W-1:0] acc;
  logic [W-1:0] hi;
  logic         cy_new;
  logic         ov_new;
  logic         ce_cy;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  alu_acc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_in),
    .b      (b_in),
    .cy     (cy_in),
    .acc    (acc),
    .hi     (hi),
    .cy_new (cy_new),
    .ov_new (ov_new),
    .ce_cy  (ce_cy),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] b;
    logic         cy;
    logic [W-1:0] acc;
    logic [W-1:0] hi;
    logic         cyn;
    logic         ovn;
    logic         ce;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present one start for a single clock; returns at the negedge after the
  // sampling edge, where single-cycle results are already visible.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] bv, input logic c);
    @(negedge clk);
    start = 1'b1;
    op_in = o;
    b_in  = bv;
    cy_in = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy samples until done is seen (bounded).
  task automatic wait_done(output int nbusy);
    int cyc;
    nbusy = 0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) nbusy++;
      chk("no_early_done", {15'd0, done}, 16'd0);
      b_in  = 8'hA5;  // operand input changes must not matter while busy
      cy_in = ~cy_in;
      @(negedge clk);
      cyc++;
    end
    chk("done_within_bound", {15'd0, done}, 16'd1);
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eh,
                            input logic ec, input logic eo);
    chk({tag, "_acc"}, {8'd0, acc}, {8'd0, ea});
    chk({tag, "_hi"},  {8'd0, hi},  {8'd0, eh});
    chk({tag, "_cy"},  {15'd0, cy_new}, {15'd0, ec});
    chk({tag, "_ov"},  {15'd0, ov_new}, {15'd0, eo});
    chk({tag, "_ce"},  {15'd0, ce_cy}, 16'd1);
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int nb;

    // op, b, cy | acc, hi, cy_new, ov_new, ce_cy
    vecs.push_back('{4'd0,  8'h7F, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0}); // LD
    vecs.push_back('{4'd1,  8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1}); // ADD ovf
    vecs.push_back('{4'd0,  8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0}); // LD keeps flags
    vecs.push_back('{4'd3,  8'h01, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1}); // SUB borrow
    vecs.push_back('{4'd2,  8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1}); // ADC carry in
    vecs.push_back('{4'd0,  8'h0F, 1'b0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0}); // LD
    vecs.push_back('{4'd4,  8'h10, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1}); // SBB
    vecs.push_back('{4'd5,  8'hF0, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1}); // AND
    vecs.push_back('{4'd6,  8'h0C, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b1}); // OR
    vecs.push_back('{4'd7,  8'hFF, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1}); // XOR
    vecs.push_back('{4'd0,  8'h40, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0}); // LD
    vecs.push_back('{4'd8,  8'h00, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1}); // SHL ov
    vecs.push_back('{4'd8,  8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1}); // SHL cy+ov
    vecs.push_back('{4'd0,  8'h81, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1, 1'b0}); // LD
    vecs.push_back('{4'd9,  8'h00, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1}); // SHR
    vecs.push_back('{4'd12, 8'h33, 1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0}); // reserved
    vecs.push_back('{4'd0,  8'h80, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0}); // LD
    vecs.push_back('{4'd1,  8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1}); // ADD neg ovf
    vecs.push_back('{4'd0,  8'h80, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0}); // LD
    vecs.push_back('{4'd3,  8'h01, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1}); // SUB ovf
    vecs.push_back('{4'd2,  8'h01, 1'b1, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1}); // ADC ovf
    vecs.push_back('{4'd4,  8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1}); // SBB cy=0

    rst   = 1'b1;
    start = 1'b0;
    op_in = 4'd0;
    b_in  = '0;
    cy_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc",  {8'd0, acc}, 16'd0);
    chk("rst_hi",   {8'd0, hi},  16'd0);
    chk("rst_cy",   {15'd0, cy_new}, 16'd0);
    chk("rst_ov",   {15'd0, ov_new}, 16'd0);
    chk("rst_ce",   {15'd0, ce_cy}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;

    // ---------------- single-cycle table ----------------
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].b, vecs[i].cy);
      $display("vec %0d op=%0d b=%02h cy=%0b -> acc=%02h hi=%02h cy_new=%0b ov_new=%0b ce=%0b",
               i, vecs[i].op, vecs[i].b, vecs[i].cy, acc, hi, cy_new, ov_new, ce_cy);
      chk($sformatf("v%0d_acc", i), {8'd0, acc}, {8'd0, vecs[i].acc});
      chk($sformatf("v%0d_hi", i),  {8'd0, hi},  {8'd0, vecs[i].hi});
      chk($sformatf("v%0d_cy", i),  {15'd0, cy_new}, {15'd0, vecs[i].cyn});
      chk($sformatf("v%0d_ov", i),  {15'd0, ov_new}, {15'd0, vecs[i].ovn});
      chk($sformatf("v%0d_ce", i),  {15'd0, ce_cy}, {15'd0, vecs[i].ce});
      chk($sformatf("v%0d_done", i), {15'd0, done}, 16'd1);
      chk($sformatf("v%0d_busy", i), {15'd0, busy}, 16'd0);
    end
    // done/ce_cy are single pulses
    @(negedge clk);
    chk("idle_done", {15'd0, done}, 16'd0);
    chk("idle_ce",   {15'd0, ce_cy}, 16'd0);

    // ---------------- MUL 200*3 = 0x0258 ----------------
    issue(4'd0, 8'd200, 1'b0);
    issue(4'd10, 8'd3, 1'b0);
    wait_done(nb);
    $display("mul 200*3: busy=%0d acc=%02h hi=%02h cy=%0b ov=%0b", nb, acc, hi, cy_new, ov_new);
    chk("mul_busy_cycles", nb[15:0], 16'd8);
    chk_result("mul", 8'h58, 8'h02, 1'b1, 1'b1);
    @(negedge clk);
    chk("mul_done_pulse", {15'd0, done}, 16'd0);
    chk("mul_ce_pulse",   {15'd0, ce_cy}, 16'd0);

    // ---------------- DIV 200/7 = 28 r 4, then back-to-back ADD ----------------
    issue(4'd0, 8'd200, 1'b0);
    issue(4'd11, 8'd7, 1'b0);
    wait_done(nb);
    $display("div 200/7: busy=%0d acc=%02h hi=%02h cy=%0b ov=%0b", nb, acc, hi, cy_new, ov_new);
    chk("div_busy_cycles", nb[15:0], 16'd8);
    chk_result("div", 8'h1C, 8'h04, 1'b0, 1'b0);
    // start in the done cycle must be accepted
    start = 1'b1;
    op_in = 4'd1;
    b_in  = 8'h01;
    cy_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    $display("b2b add: acc=%02h done=%0b", acc, done);
    chk_result("b2b_add", 8'h1D, 8'h04, 1'b0, 1'b0);

    // ---------------- DIV by zero ----------------
    issue(4'd0, 8'h55, 1'b0);
    issue(4'd11, 8'h00, 1'b0);
    $display("div0: acc=%02h hi=%02h cy=%0b ov=%0b busy=%0b", acc, hi, cy_new, ov_new, busy);
    chk_result("div0", 8'h55, 8'h04, 1'b1, 1'b1);
    @(negedge clk);
    chk("div0_busy_after", {15'd0, busy}, 16'd0);

    // ---------------- MUL with ignored start (LD held in cycles 2-3) ----------------
    issue(4'd0, 8'h10, 1'b0);
    issue(4'd10, 8'h05, 1'b0);
    chk("mul2_busy1", {15'd0, busy}, 16'd1);
    start = 1'b1;
    op_in = 4'd0;
    b_in  = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("mul2_acc_held", {8'd0, acc}, 16'h10);
    wait_done(nb);
    $display("mul 16*5 with ignored start: busy=%0d acc=%02h hi=%02h", nb + 2, acc, hi);
    chk("mul2_busy_cycles", 16'(nb + 2), 16'd8);
    chk_result("mul2", 8'h50, 8'h00, 1'b0, 1'b0);

    // ---------------- MUL aborted by reset in busy cycle 4 ----------------
    issue(4'd0, 8'hFF, 1'b0);
    issue(4'd10, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("mul3_busy4", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("abort: acc=%02h hi=%02h busy=%0b done=%0b", acc, hi, busy, done);
    chk("abort_acc",  {8'd0, acc}, 16'd0);
    chk("abort_hi",   {8'd0, hi},  16'd0);
    chk("abort_cy",   {15'd0, cy_new}, 16'd0);
    chk("abort_ov",   {15'd0, ov_new}, 16'd0);
    chk("abort_ce",   {15'd0, ce_cy}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    // nothing left over from the aborted MUL
    repeat (10) @(negedge clk);
    chk("abort_no_done", {15'd0, done}, 16'd0);
    chk("abort_acc_stays", {8'd0, acc}, 16'd0);

    issue(4'd0, 8'h12, 1'b0);
    $display("post-reset LD: acc=%02h done=%0b", acc, done);
    chk("post_ld_acc",  {8'd0, acc}, 16'h12);
    chk("post_ld_done", {15'd0, done}, 16'd1);
    issue(4'd10, 8'h20, 1'b0);
    wait_done(nb);
    $display("post-reset mul 0x12*0x20: busy=%0d acc=%02h hi=%02h", nb, acc, hi);
    chk("post_mul_busy", nb[15:0], 16'd8);
    chk_result("post_mul", 8'h40, 8'h02, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
Name: alu_acc

Overview:
- Accumulator and ALU stage that sits directly upstream of the flags register.
- Holds the WIDTH-bit accumulator and executes one operation per start request, combining the accumulator with operand b.
- Drives the flags register's inputs: acc, cy_new, ov_new and the ce_cy strobe. The flags register derives zf/sf combinationally from acc and latches cy/ov on ce_cy.
- Executes MUL and DIV iteratively over multiple cycles, and all other operations in a single cycle.

Parameters:
WIDTH, 8, datapath width of acc, b and hi; must be >= 2

Ports:
clk     input   1       clock, all state updates on rising edge
rst     input   1       synchronous, active-high reset
start   input   1       request to execute op; sampled only when busy=0
op      input   4       operation code, sampled with start
b       input   WIDTH   second operand, sampled with start
cy      input   1       current carry flag from the flags register (used by ADC/SBB)
acc     output  WIDTH   accumulator register; connects to the flags register's acc input
hi      output  WIDTH   high product (MUL) or remainder (DIV) register
cy_new  output  1       registered carry result for the flags register
ov_new  output  1       registered overflow result for the flags register
ce_cy   output  1       registered one-cycle strobe for the flags register to load cy_new/ov_new
busy    output  1       multi-cycle operation in progress
done    output  1       one-cycle pulse: result written this cycle

Behaviour:
- Reset: when rst=1 at an edge, all of the following go to 0 and any MUL/DIV in progress is aborted: acc, hi, cy_new, ov_new, ce_cy, busy, done, FSM state (IDLE), iteration counter.
- FSM states:
  - IDLE: start=1 with a single-cycle op executes at this edge, stays in IDLE. start=1 with op MUL/DIV latches operands, sets busy=1 and the counter to WIDTH, moves to MUL or DIV.
  - MUL/DIV: performs one iteration per edge and decrements the counter. When the final iteration executes, writes the results, clears busy, returns to IDLE.
  - start is ignored while busy=1.
  - Back-to-back start in the done cycle is accepted.
- Single-cycle timing: start at edge k gives acc/hi, cy_new, ov_new, done=1 and ce_cy all updated by edge k. The flags register loads cy/ov at edge k+1.
- Default outputs: done and ce_cy are 0 in every cycle without a completion. cy_new and ov_new hold their last values.
- Operation codes (arithmetic modulo 2^WIDTH; ov = signed two's-complement overflow):
  - 0 LD: acc<=b; ce_cy=0, flags untouched.
  - 1 ADD: {cy_new,acc}<=acc+b.
  - 2 ADC: {cy_new,acc}<=acc+b+cy.
  - 3 SUB: acc<=acc-b; cy_new=borrow (1 iff acc<b unsigned).
  - 4 SBB: acc<=acc-b-cy; cy_new=borrow.
  - 5 AND, 6 OR, 7 XOR: bitwise; cy_new=0, ov_new=0.
  - 8 SHL: acc<=acc<<1; cy_new=old acc[WIDTH-1]; ov_new=old acc[WIDTH-1]^acc[WIDTH-2].
  - 9 SHR (logical): acc<=acc>>1; cy_new=old acc[0]; ov_new=0.
  - 10 MUL (unsigned, shift-add): {hi,acc}<=acc*b; cy_new=ov_new=(hi!=0).
  - 11 DIV (unsigned, restoring): acc<=quotient, hi<=remainder; cy_new=ov_new=0.
  - 12-15: reserved; done=1, ce_cy=0, no register change.
- MUL/DIV timing: start at edge k; busy=1 from after edge k through edge k+WIDTH; results, done=1 and ce_cy=1 are registered at edge k+WIDTH, with busy=0 at the same edge.
- Divide by zero (b=0): single-cycle; acc and hi unchanged; cy_new=1, ov_new=1, ce_cy=1, done=1; busy never asserts.
- Operands acc and b are captured at start; changes to the b or cy inputs during busy have no effect.
- hi is written only by MUL and DIV.
- Arithmetic ops (ADD..DIV) drive ce_cy=1 and cy_new/ov_new in their done cycle.

Test Plan:
- After rst: LD 0x7F, then ADD b=0x01 -> next cycle acc=0x80, cy_new=0, ov_new=1, ce_cy=1, done=1.
- LD 0x00, SUB b=0x01 -> acc=0xFF, cy_new=1, ov_new=0. Then with cy=1, ADC b=0x00 on acc=0xFF -> acc=0x00, cy_new=1, ov_new=0.
- LD 200, MUL b=3 -> busy high exactly 8 cycles; then acc=0x58, hi=0x02, cy_new=ov_new=1, single done/ce_cy pulse.
- LD 200, DIV b=7 -> after 8 busy cycles acc=0x1C, hi=0x04, cy_new=ov_new=0.
- DIV b=0 on acc=0x55 -> next cycle done=1, acc=0x55, cy_new=ov_new=1, busy stays 0.
- MUL started; start=1 with LD held during cycles 2-3 -> ignored. Second MUL, then rst asserted in busy cycle 4 -> all outputs 0 next cycle; next start accepted normally.
